onehot_sel_mux_pipe: RTL and testbench

//  Parametrised one-hot select mux with a registered output stage, for datapath

---
 rtl/onehot_sel_mux_pipe.sv | 96 +++++++++
 tb/tb_onehot_sel_mux_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_sel_mux_pipe.sv
// onehot_sel_mux_pipe: one-hot (or lowest-index priority) channel select mux
// feeding a 1-deep valid/ready output register. It also flags multi-hot and
// no-hot selects per beat and keeps a saturating multi-hot error counter.
module onehot_sel_mux_pipe #(
    parameter int WIDTH    = 32,
    parameter int NCH      = 4,
    parameter int MODE     = 0,
    parameter int ERRCNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH-1:0]        sel,
    input  logic [NCH*WIDTH-1:0]  data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_multi,
    output logic                  out_none,
    input  logic                  clr_err,
    output logic [ERRCNT_W-1:0]   err_cnt
);

    // Packed view of the flat data bus: ch[i] is data[i*WIDTH +: WIDTH].
    logic [NCH-1:0][WIDTH-1:0] ch;
    logic [WIDTH-1:0]          sel_data;
    logic                      sel_multi;
    logic                      sel_none;
    logic                      seen;
    logic                      accept;

    assign ch = data;

    generate
        if (MODE == 0) begin : g_and_or
            // AND-OR combine: every selected channel contributes its bits.
            always_comb begin
                sel_data = '0;
                for (int i = 0; i < NCH; i++)
                    sel_data = sel_data | (ch[i] & {WIDTH{sel[i]}});
            end
        end else begin : g_prio
            // Lowest index wins: scan from the top so the last hit is the lowest.
            always_comb begin
                sel_data = '0;
                for (int i = NCH - 1; i >= 0; i--)
                    if (sel[i]) sel_data = ch[i];
            end
        end
    endgenerate

    // popcount(sel) >= 2 without a full adder tree: a second set bit after one seen.
    always_comb begin
        seen      = 1'b0;
        sel_multi = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel[i]) begin
                sel_multi = sel_multi | seen;
                seen      = 1'b1;
            end
        end
    end

    assign sel_none = ~|sel;

    // Register is free when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Output buffer: load on accept, drop valid on a drain with no new beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_multi <= 1'b0;
            out_none  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_multi <= sel_multi;
            out_none  <= sel_none;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating multi-hot counter; a clear beats a simultaneous increment.
    always_ff @(posedge clk) begin
        if (rst || clr_err)
            err_cnt <= '0;
        else if (accept && sel_multi && (err_cnt != {ERRCNT_W{1'b1}}))
            err_cnt <= err_cnt + ERRCNT_W'(1);
    end

endmodule

// File: tb/tb_onehot_sel_mux_pipe.sv
// Bench for onehot_sel_mux_pipe: three instances (AND-OR, priority, AND-OR with
// a 2-bit counter) share one stimulus; a vector table covers the mux function,
// directed sequences cover backpressure, saturation/clear and reset, and a
// random phase compares against a small reference model.
module tb_onehot_sel_mux_pipe;

    localparam int W = 2;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [N-1:0] sel;
    logic [N*W-1:0] data;
    logic         clr_err;

    logic         rdy0, rdy1, rdy2;
    logic         vld0, vld1, vld2;
    logic [W-1:0] dat0, dat1, dat2;
    logic         mul0, mul1, mul2;
    logic         non0, non1, non2;
    logic [7:0]   err0, err1;
    logic [1:0]   err2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_sel_mux_pipe #(.WIDTH(W), .NCH(N), .MODE(0), .ERRCNT_W(8)) u_m0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .sel(sel),
        .data(data), .out_valid(vld0), .out_ready(out_ready), .out_data(dat0),
        .out_multi(mul0), .out_none(non0), .clr_err(clr_err), .err_cnt(err0));

    onehot_sel_mux_pipe #(.WIDTH(W), .NCH(N), .MODE(1), .ERRCNT_W(8)) u_m1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .sel(sel),
        .data(data), .out_valid(vld1), .out_ready(out_ready), .out_data(dat1),
        .out_multi(mul1), .out_none(non1), .clr_err(clr_err), .err_cnt(err1));

    onehot_sel_mux_pipe #(.WIDTH(W), .NCH(N), .MODE(0), .ERRCNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .sel(sel),
        .data(data), .out_valid(vld2), .out_ready(out_ready), .out_data(dat2),
        .out_multi(mul2), .out_none(non2), .clr_err(clr_err), .err_cnt(err2));

    typedef struct {
        logic [2:0] sel;
        logic [5:0] data;
        logic [1:0] exp0;   // AND-OR result
        logic [1:0] exp1;   // lowest-index result
        logic       multi;
        logic       none;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_or(input logic [2:0] s, input logic [5:0] d);
        logic [1:0] r;
        r = 2'b00;
        for (int i = 0; i < N; i++)
            for (int b = 0; b < W; b++)
                if (s[i] && d[i*W+b]) r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic [1:0] ref_prio(input logic [2:0] s, input logic [5:0] d);
        if (s[0]) return d[1:0];
        if (s[1]) return d[3:2];
        if (s[2]) return d[5:4];
        return 2'b00;
    endfunction

    function automatic logic ref_multi(input logic [2:0] s);
        return (int'(s[0]) + int'(s[1]) + int'(s[2])) >= 2;
    endfunction

    task automatic drive(input logic v, input logic [2:0] s, input logic [5:0] d,
                         input logic ordy, input logic clr);
        in_valid  = v;
        sel       = s;
        data      = d;
        out_ready = ordy;
        clr_err   = clr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 3'b000, 6'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // random-phase reference state
    logic       m_valid, m_multi, m_none;
    logic [1:0] m_d0, m_d1;
    int         m_err8, m_err2, nmulti;
    logic       exp_rdy, acc;

    initial begin
        // ch2, ch1, ch0
        tbl[0]  = '{3'b001, 6'b10_01_00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{3'b010, 6'b10_01_00, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[2]  = '{3'b100, 6'b10_01_00, 2'b10, 2'b10, 1'b0, 1'b0};
        tbl[3]  = '{3'b110, 6'b10_01_00, 2'b11, 2'b01, 1'b1, 1'b0};
        tbl[4]  = '{3'b111, 6'b10_01_00, 2'b11, 2'b00, 1'b1, 1'b0};
        tbl[5]  = '{3'b011, 6'b10_01_00, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[6]  = '{3'b101, 6'b10_01_00, 2'b10, 2'b00, 1'b1, 1'b0};
        tbl[7]  = '{3'b000, 6'b10_01_00, 2'b00, 2'b00, 1'b0, 1'b1};
        tbl[8]  = '{3'b011, 6'b11_10_01, 2'b11, 2'b01, 1'b1, 1'b0};
        tbl[9]  = '{3'b110, 6'b11_10_01, 2'b11, 2'b10, 1'b1, 1'b0};
        tbl[10] = '{3'b000, 6'b11_10_01, 2'b00, 2'b00, 1'b0, 1'b1};
        tbl[11] = '{3'b100, 6'b11_10_01, 2'b11, 2'b11, 1'b0, 1'b0};

        rst = 1'b1;
        drive(1'b0, 3'b000, 6'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset out_valid", vld0, 0);
        chk("reset out_data", dat0, 0);
        chk("reset err_cnt", err0, 0);
        rst = 1'b0;

        // table: back-to-back beats, each checked one cycle after it is driven
        nmulti = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].sel, tbl[i].data, 1'b1, 1'b0);
            #1 chk("tbl in_ready", rdy0, 1);
            @(negedge clk);
            if (tbl[i].multi) nmulti++;
            chk($sformatf("tbl[%0d] out_valid", i), vld0, 1);
            chk($sformatf("tbl[%0d] m0 data", i), dat0, tbl[i].exp0);
            chk($sformatf("tbl[%0d] m1 data", i), dat1, tbl[i].exp1);
            chk($sformatf("tbl[%0d] multi", i), {mul0, mul1}, {2{tbl[i].multi}});
            chk($sformatf("tbl[%0d] none", i), {non0, non1}, {2{tbl[i].none}});
            chk($sformatf("tbl[%0d] err_cnt", i), err0, nmulti);
        end
        drive(1'b0, 3'b000, 6'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("drain out_valid", vld0, 0);
        chk("drain data hold", dat0, 2'b11);
        chk("tbl err_cnt m1", err1, 6);
        chk("tbl err_cnt sat", err2, 3);

        // backpressure
        drive(1'b1, 3'b100, 6'b10_01_00, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp first", dat0, 2'b10);
        drive(1'b1, 3'b010, 6'b10_01_00, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp in_ready low", rdy0, 0);
            @(negedge clk);
            chk("bp data stable", dat0, 2'b10);
            chk("bp out_valid", vld0, 1);
        end
        out_ready = 1'b1;
        #1 chk("bp in_ready high", rdy0, 1);
        @(negedge clk);
        chk("bp second", dat0, 2'b01);
        chk("bp second valid", vld0, 1);
        drive(1'b0, 3'b000, 6'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp drained", vld0, 0);

        // saturation and clear-wins
        drive(1'b0, 3'b000, 6'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("clr idle", err2, 0);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 3'b111, 6'b10_01_00, 1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("sat beat %0d", i), err2, (i > 3) ? 3 : i);
        end
        chk("sat wide cnt", err0, 5);
        drive(1'b1, 3'b110, 6'b10_01_00, 1'b1, 1'b1);
        @(negedge clk);
        chk("clr+multi sat", err2, 0);
        chk("clr+multi wide", err0, 0);
        chk("clr+multi beat", {vld0, mul0, dat0}, {1'b1, 1'b1, 2'b11});

        // reset while holding a stalled beat
        drive(1'b1, 3'b011, 6'b10_01_00, 1'b1, 1'b0);
        @(negedge clk);
        chk("pre-rst err", err0, 1);
        drive(1'b1, 3'b110, 6'b10_01_00, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 3'b000, 6'b0, 1'b0, 1'b0);
        #1;
        chk("rst out_valid", vld0, 0);
        chk("rst out_data", dat0, 0);
        chk("rst flags", {mul0, non0}, 0);
        chk("rst err_cnt", err0, 0);
        chk("rst in_ready", rdy0, 1);

        // random phase vs reference model
        do_reset();
        m_valid = 0; m_multi = 0; m_none = 0; m_d0 = 0; m_d1 = 0;
        m_err8 = 0; m_err2 = 0;
        for (int c = 0; c < 4000; c++) begin
            drive(($urandom_range(0, 9) < 7), 3'($urandom), 6'($urandom),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
            #1;
            exp_rdy = !m_valid || out_ready;
            chk("rnd in_ready", {rdy0, rdy1, rdy2}, {3{exp_rdy}});
            chk("rnd out_valid", {vld0, vld1}, {2{m_valid}});
            if (m_valid) begin
                chk("rnd m0 data", dat0, m_d0);
                chk("rnd m1 data", dat1, m_d1);
                chk("rnd flags", {mul0, non0, mul1, non1}, {m_multi, m_none, m_multi, m_none});
            end
            chk("rnd err8", err0, m_err8);
            chk("rnd err2", err2, m_err2);
            acc = in_valid && exp_rdy;
            if (clr_err) begin
                m_err8 = 0; m_err2 = 0;
            end else if (acc && ref_multi(sel)) begin
                if (m_err8 < 255) m_err8++;
                if (m_err2 < 3) m_err2++;
            end
            if (acc) begin
                m_valid = 1;
                m_d0    = ref_or(sel, data);
                m_d1    = ref_prio(sel, data);
                m_multi = ref_multi(sel);
                m_none  = (sel == 3'b000);
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
